// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg
//   Shared definitions for the ALU request/response sequencer:
//   opcode width and encodings, FSM state encodings.
package alu_sequencer_pkg;

    localparam int OP_W    = 3;
    localparam int NUM_OPS = 8;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_INV = 3'd5,
        OP_CLR = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_RESP = 2'd3
    } state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if
//   Request/response bus between the instruction decoder (master) and
//   the ALU sequencer (slave).
//   req_valid/req_ready/req_op/req_a/req_b : request handshake + payload
//   rsp_valid/rsp_ready/rsp_result/rsp_overflow : response handshake + payload
//   busy : sequencer is working on or holding an operation
interface alu_sequencer_if #(
    parameter int DATA_WIDTH = 8
);
    import alu_sequencer_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic [OP_W-1:0]       req_op;
    logic [DATA_WIDTH-1:0] req_a;
    logic [DATA_WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_result;
    logic                  rsp_overflow;
    logic                  busy;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_overflow, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_overflow, busy
    );

endinterface

// File: rtl/alu_sequencer_op_decoder.sv
// alu_op_decoder
//   Combinational opcode -> one-hot ALU strobe mapping.
//   i_op  : opcode
//   i_en  : strobes are only driven while enabled
//   o_add .. o_clr : one-hot strobes (MUL drives o_add, since multiply
//                    is built from repeated adds)
module alu_op_decoder
    import alu_sequencer_pkg::*;
(
    input  op_e  i_op,
    input  logic i_en,
    output logic o_add,
    output logic o_sub,
    output logic o_and,
    output logic o_or,
    output logic o_xor,
    output logic o_inv,
    output logic o_clr
);

    logic [OP_W-1:0]    w_op;
    logic [NUM_OPS-1:0] w_hit;

    assign w_op = i_op;

    generate
        for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_hit
            assign w_hit[gi] = i_en && (w_op == OP_W'(gi));
        end
    endgenerate

    assign o_add = w_hit[int'(OP_ADD)] | w_hit[int'(OP_MUL)];
    assign o_sub = w_hit[int'(OP_SUB)];
    assign o_and = w_hit[int'(OP_AND)];
    assign o_or  = w_hit[int'(OP_OR)];
    assign o_xor = w_hit[int'(OP_XOR)];
    assign o_inv = w_hit[int'(OP_INV)];
    assign o_clr = w_hit[int'(OP_CLR)];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Controller between the instruction decoder and an external 8-bit ALU.
//   Accepts one request at a time, runs it on the ALU (one cycle for plain
//   ops, DATA_WIDTH shift-and-add cycles for MUL) and holds the result until
//   the consumer takes it.
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : request/response handshake, busy
//   alu_add..alu_clr  : one-hot ALU strobes
//   alu_in1, alu_in2  : ALU operands
//   alu_out           : ALU result
//   alu_overflow      : ALU carry out
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_sequencer_if.slave        bus,
    output logic                  alu_add,
    output logic                  alu_sub,
    output logic                  alu_and,
    output logic                  alu_or,
    output logic                  alu_xor,
    output logic                  alu_inv,
    output logic                  alu_clr,
    output logic [DATA_WIDTH-1:0] alu_in1,
    output logic [DATA_WIDTH-1:0] alu_in2,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  alu_overflow
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    state_e                r_state;
    state_e                w_state_next;
    op_e                   r_op;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_mcand;
    logic [DATA_WIDTH-1:0] r_mult;
    logic                  r_lost;
    logic                  r_ovf;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_rsp_result;
    logic                  r_rsp_overflow;

    logic                  w_strobe_en;
    logic                  w_mul_last;
    logic                  w_ovf_next;

    assign w_mul_last = (r_cnt == CNT_W'(DATA_WIDTH - 1));

    // Product overflows if the adder carries, or if a multiplier bit selects
    // a partial product whose top bits were already shifted out of mcand.
    assign w_ovf_next = r_ovf | alu_overflow | (r_mult[0] & r_lost);

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM next-state / outputs ----------------
    always_comb begin
        w_state_next = r_state;
        w_strobe_en  = 1'b0;
        alu_in1      = '0;
        alu_in2      = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_state_next = (op_e'(bus.req_op) == OP_MUL) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: begin
                w_strobe_en  = 1'b1;
                alu_in1      = r_a;
                alu_in2      = r_b;
                w_state_next = S_RESP;
            end
            S_MUL: begin
                w_strobe_en = 1'b1;
                alu_in1     = r_acc;
                alu_in2     = r_mult[0] ? r_mcand : '0;
                if (w_mul_last) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op           <= OP_ADD;
            r_a            <= '0;
            r_b            <= '0;
            r_acc          <= '0;
            r_mcand        <= '0;
            r_mult         <= '0;
            r_lost         <= 1'b0;
            r_ovf          <= 1'b0;
            r_cnt          <= '0;
            r_rsp_result   <= '0;
            r_rsp_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_op    <= op_e'(bus.req_op);
                        r_a     <= bus.req_a;
                        r_b     <= bus.req_b;
                        r_acc   <= '0;
                        r_mcand <= bus.req_a;
                        r_mult  <= bus.req_b;
                        r_lost  <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                S_EXEC: begin
                    r_rsp_result   <= alu_out;
                    r_rsp_overflow <= alu_overflow;
                end
                S_MUL: begin
                    r_acc   <= alu_out;
                    r_ovf   <= w_ovf_next;
                    r_lost  <= r_lost | r_mcand[DATA_WIDTH-1];
                    r_mcand <= r_mcand << 1;
                    r_mult  <= r_mult >> 1;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_mul_last) begin
                        r_rsp_result   <= alu_out;
                        r_rsp_overflow <= w_ovf_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- Strobe decode ----------------
    alu_op_decoder u_dec (
        .i_op  (r_op),
        .i_en  (w_strobe_en),
        .o_add (alu_add),
        .o_sub (alu_sub),
        .o_and (alu_and),
        .o_or  (alu_or),
        .o_xor (alu_xor),
        .o_inv (alu_inv),
        .o_clr (alu_clr)
    );

    assign bus.req_ready    = (r_state == S_IDLE);
    assign bus.rsp_valid    = (r_state == S_RESP);
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.rsp_result   = r_rsp_result;
    assign bus.rsp_overflow = r_rsp_overflow;

endmodule
